// File: rtl/id_ex_register_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : id_ex_register_pkg                                            |
// | Purpose  : Shared types and constants for the ID/EX pipeline register:   |
// |            stall FSM state encoding, default ALU op width, the           |
// |            hard-wired zero register number, bubble counter width and a   |
// |            saturating increment helper.                                  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package id_ex_register_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int         DEF_ALUOP_W = 6;
   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         CNT_W       = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_register_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_detect                                                 |
// | Purpose  : Combinational load-use hazard detection for the ID/EX stage.  |
// | Ports    : mem_read_ex, valid_ex, rt_ex - load currently in EX           |
// |            rs_id, rt_id                - sources of instruction in ID    |
// |            flush                       - EX-resolved redirect            |
// |            state                       - stall FSM state (RUN/HOLD)      |
// |            hazard                      - bubble must be inserted         |
// |            stall                       - hold PC and IF/ID this cycle    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hazard_detect
   import id_ex_register_pkg::*;
(
   input  logic       mem_read_ex,
   input  logic       valid_ex,
   input  logic [4:0] rt_ex,
   input  logic [4:0] rs_id,
   input  logic [4:0] rt_id,
   input  logic       flush,
   input  state_t     state,
   output logic       hazard,
   output logic       stall
);

   // In HOLD the bubble has already cleared MemRead_EX; the explicit state
   // gate guarantees a single stall cycle per load regardless.
   assign hazard = mem_read_ex && valid_ex && (rt_ex != REG_ZERO) &&
                   ((rt_ex == rs_id) || (rt_ex == rt_id)) && (state == RUN);

   // A flush squashes the ID instruction, so there is nothing to stall for.
   assign stall = hazard && !flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : id_ex_register                                                |
// | Purpose  : ID/EX pipeline register with load-use bubble insertion,       |
// |            flush squashing and a saturating bubble counter.              |
// | Ports    : Clk_in, Rst_n_in (sync, active-low)                           |
// |            *_ID decode control/data/specifiers in, Flush_in              |
// |            *_EX registered copies, Valid_EX                              |
// |            Stall_out (combinational), BubbleCount_out (16-bit, sat.)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module id_ex_register
   import id_ex_register_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = DEF_ALUOP_W
)
(
   input  logic               Clk_in,
   input  logic               Rst_n_in,
   input  logic               RegWrite_ID,
   input  logic               MemtoReg_ID,
   input  logic               Branch_ID,
   input  logic               MemRead_ID,
   input  logic               MemWrite_ID,
   input  logic               RegDst_ID,
   input  logic               ALUSrc_ID,
   input  logic               JR_ID,
   input  logic [ALUOP_W-1:0] ALUOp_ID,
   input  logic [1:0]         size_ID,
   input  logic [DATA_W-1:0]  PCAddResult_ID,
   input  logic [DATA_W-1:0]  ReadData1_ID,
   input  logic [DATA_W-1:0]  ReadData2_ID,
   input  logic [DATA_W-1:0]  SignExtResult_ID,
   input  logic [4:0]         rs_ID,
   input  logic [4:0]         rt_ID,
   input  logic [4:0]         rd_ID,
   input  logic               Flush_in,
   output logic               RegWrite_EX,
   output logic               MemtoReg_EX,
   output logic               Branch_EX,
   output logic               MemRead_EX,
   output logic               MemWrite_EX,
   output logic               RegDst_EX,
   output logic               ALUSrc_EX,
   output logic               JR_EX,
   output logic [ALUOP_W-1:0] ALUOp_EX,
   output logic [1:0]         size_EX,
   output logic [DATA_W-1:0]  PCAddResult_EX,
   output logic [DATA_W-1:0]  ReadData1_EX,
   output logic [DATA_W-1:0]  ReadData2_EX,
   output logic [DATA_W-1:0]  SignExtResult_EX,
   output logic [4:0]         rt_EX,
   output logic [4:0]         rd_EX,
   output logic               Valid_EX,
   output logic               Stall_out,
   output logic [CNT_W-1:0]   BubbleCount_out
);

   state_t state;
   logic   hazard;

   hazard_detect u_hazard_detect (
      .mem_read_ex (MemRead_EX),
      .valid_ex    (Valid_EX),
      .rt_ex       (rt_EX),
      .rs_id       (rs_ID),
      .rt_id       (rt_ID),
      .flush       (Flush_in),
      .state       (state),
      .hazard      (hazard),
      .stall       (Stall_out)
   );

   always_ff @(posedge Clk_in) begin
      if (!Rst_n_in || Flush_in || hazard) begin
         // Reset and bubbles both empty the EX slot completely.
         RegWrite_EX      <= 1'b0;
         MemtoReg_EX      <= 1'b0;
         Branch_EX        <= 1'b0;
         MemRead_EX       <= 1'b0;
         MemWrite_EX      <= 1'b0;
         RegDst_EX        <= 1'b0;
         ALUSrc_EX        <= 1'b0;
         JR_EX            <= 1'b0;
         ALUOp_EX         <= '0;
         size_EX          <= '0;
         PCAddResult_EX   <= '0;
         ReadData1_EX     <= '0;
         ReadData2_EX     <= '0;
         SignExtResult_EX <= '0;
         rt_EX            <= '0;
         rd_EX            <= '0;
         Valid_EX         <= 1'b0;
      end else begin
         RegWrite_EX      <= RegWrite_ID;
         MemtoReg_EX      <= MemtoReg_ID;
         Branch_EX        <= Branch_ID;
         MemRead_EX       <= MemRead_ID;
         MemWrite_EX      <= MemWrite_ID;
         RegDst_EX        <= RegDst_ID;
         ALUSrc_EX        <= ALUSrc_ID;
         JR_EX            <= JR_ID;
         ALUOp_EX         <= ALUOp_ID;
         size_EX          <= size_ID;
         PCAddResult_EX   <= PCAddResult_ID;
         ReadData1_EX     <= ReadData1_ID;
         ReadData2_EX     <= ReadData2_ID;
         SignExtResult_EX <= SignExtResult_ID;
         rt_EX            <= rt_ID;
         rd_EX            <= rd_ID;
         Valid_EX         <= 1'b1;
      end

      // State and counter: reset, then flush, then hazard, then load.
      if (!Rst_n_in) begin
         state           <= RUN;
         BubbleCount_out <= '0;
      end else if (Flush_in) begin
         state           <= RUN;
         BubbleCount_out <= sat_inc(BubbleCount_out);
      end else if (hazard) begin
         state           <= HOLD;
         BubbleCount_out <= sat_inc(BubbleCount_out);
      end else begin
         state           <= RUN;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_id_ex_register                                             |
// | Purpose  : Self-checking bench for id_ex_register: table of cycle        |
// |            vectors with a scoreboard queue of expected EX contents,      |
// |            plus a hand-written bubble-counter saturation sequence.       |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_id_ex_register;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        regw = 0, mtr = 0, br = 0, mr = 0, mw = 0, rdst = 0, asrc = 0, jr = 0;
   logic [5:0]  aluop = '0;
   logic [1:0]  size = '0;
   logic [31:0] pc = '0, rd1 = '0, rd2 = '0, sx = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic        flush = 1'b0;

   logic        regw_ex, mtr_ex, br_ex, mr_ex, mw_ex, rdst_ex, asrc_ex, jr_ex;
   logic [5:0]  aluop_ex;
   logic [1:0]  size_ex;
   logic [31:0] pc_ex, rd1_ex, rd2_ex, sx_ex;
   logic [4:0]  rt_ex, rd_ex;
   logic        valid_ex, stall;
   logic [15:0] cnt;

   always #5 clk = ~clk;

   id_ex_register #(.DATA_W(32), .ALUOP_W(6)) dut (
      .Clk_in(clk), .Rst_n_in(rst_n),
      .RegWrite_ID(regw), .MemtoReg_ID(mtr), .Branch_ID(br), .MemRead_ID(mr),
      .MemWrite_ID(mw), .RegDst_ID(rdst), .ALUSrc_ID(asrc), .JR_ID(jr),
      .ALUOp_ID(aluop), .size_ID(size),
      .PCAddResult_ID(pc), .ReadData1_ID(rd1), .ReadData2_ID(rd2), .SignExtResult_ID(sx),
      .rs_ID(rs), .rt_ID(rt), .rd_ID(rd), .Flush_in(flush),
      .RegWrite_EX(regw_ex), .MemtoReg_EX(mtr_ex), .Branch_EX(br_ex), .MemRead_EX(mr_ex),
      .MemWrite_EX(mw_ex), .RegDst_EX(rdst_ex), .ALUSrc_EX(asrc_ex), .JR_EX(jr_ex),
      .ALUOp_EX(aluop_ex), .size_EX(size_ex),
      .PCAddResult_EX(pc_ex), .ReadData1_EX(rd1_ex), .ReadData2_EX(rd2_ex),
      .SignExtResult_EX(sx_ex), .rt_EX(rt_ex), .rd_EX(rd_ex),
      .Valid_EX(valid_ex), .Stall_out(stall), .BubbleCount_out(cnt)
   );

   typedef struct packed {
      logic        regw, mtr, br, mr, mw, rdst, asrc, jr;
      logic [5:0]  aluop;
      logic [1:0]  size;
      logic [31:0] pc, rd1, rd2, sx;
      logic [4:0]  rt, rd;
      logic        valid;
      logic [15:0] cnt;
   } out_t;

   typedef struct {
      bit          rst_n, flush, mr;
      logic [4:0]  rs, rt;
      bit          chk_stall, exp_stall, exp_valid;
      logic [15:0] exp_cnt;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];
   out_t sb_q [$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(bit r, bit f, bit m, logic [4:0] s, logic [4:0] t,
                               bit cs, bit es, bit ev, logic [15:0] ec);
      vec_t v;
      v.rst_n = r; v.flush = f; v.mr = m; v.rs = s; v.rt = t;
      v.chk_stall = cs; v.exp_stall = es; v.exp_valid = ev; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic out_t dut_out();
      out_t o;
      o = '{regw_ex, mtr_ex, br_ex, mr_ex, mw_ex, rdst_ex, asrc_ex, jr_ex,
            aluop_ex, size_ex, pc_ex, rd1_ex, rd2_ex, sx_ex, rt_ex, rd_ex,
            valid_ex, cnt};
      return o;
   endfunction

   // Drive one ID-stage instruction; everything not fixed by the vector is random.
   task automatic drive(input vec_t v);
      rst_n = v.rst_n; flush = v.flush; mr = v.mr; rs = v.rs; rt = v.rt;
      regw = 1'($urandom); mtr = 1'($urandom); br = 1'($urandom); mw = 1'($urandom);
      rdst = 1'($urandom); asrc = 1'($urandom); jr = 1'($urandom);
      aluop = 6'($urandom); size = 2'($urandom); rd = 5'($urandom);
      pc = $urandom; rd1 = $urandom; rd2 = $urandom; sx = $urandom;
   endtask

   initial begin
      out_t exp;
      out_t act;
      // before-edge state noted per line; EX empty after reset
      vecs[0]  = mk(0, 0, 1, 5'd3, 5'd3, 0, 0, 0, 16'd0); // reset, random inputs
      vecs[1]  = mk(0, 1, 1, 5'd7, 5'd1, 1, 0, 0, 16'd0); // reset held 2nd cycle
      vecs[2]  = mk(1, 0, 1, 5'd1, 5'd5, 1, 0, 1, 16'd0); // lw rt=5 enters EX
      vecs[3]  = mk(1, 0, 0, 5'd5, 5'd7, 1, 1, 0, 16'd1); // rs==5: stall, bubble
      vecs[4]  = mk(1, 0, 0, 5'd5, 5'd7, 1, 0, 1, 16'd1); // HOLD: dependent loads
      vecs[5]  = mk(1, 0, 1, 5'd0, 5'd0, 1, 0, 1, 16'd1); // lw rt=0
      vecs[6]  = mk(1, 0, 0, 5'd0, 5'd3, 1, 0, 1, 16'd1); // rs=0 vs rt_EX=0: none
      vecs[7]  = mk(1, 0, 1, 5'd2, 5'd9, 1, 0, 1, 16'd1); // lw rt=9
      vecs[8]  = mk(1, 1, 0, 5'd4, 5'd9, 1, 0, 0, 16'd2); // flush + hazard
      vecs[9]  = mk(1, 0, 1, 5'd1, 5'd6, 1, 0, 1, 16'd2); // lw rt=6
      vecs[10] = mk(1, 0, 0, 5'd1, 5'd6, 1, 1, 0, 16'd3); // rt==6: stall -> HOLD
      vecs[11] = mk(0, 0, 1, 5'd6, 5'd6, 1, 0, 0, 16'd0); // reset during HOLD
      vecs[12] = mk(1, 0, 0, 5'd6, 5'd6, 1, 0, 1, 16'd0); // no residual stall
      vecs[13] = mk(1, 1, 0, 5'd1, 5'd2, 1, 0, 0, 16'd1); // plain flush
      vecs[14] = mk(1, 0, 1, 5'd0, 5'd8, 1, 0, 1, 16'd1); // lw rt=8
      vecs[15] = mk(0, 1, 0, 5'd8, 5'd1, 1, 0, 0, 16'd0); // reset beats flush+hazard
      vecs[16] = mk(1, 0, 0, 5'd3, 5'd4, 1, 0, 1, 16'd0); // normal load after reset

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         if (vecs[i].chk_stall)
            check($sformatf("vec%0d stall", i), 192'(stall), 192'(vecs[i].exp_stall));
         if (vecs[i].exp_valid)
            exp = '{regw, mtr, br, mr, mw, rdst, asrc, jr, aluop, size,
                    pc, rd1, rd2, sx, rt, rd, 1'b1, vecs[i].exp_cnt};
         else begin
            exp = '0;
            exp.cnt = vecs[i].exp_cnt;
         end
         sb_q.push_back(exp);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL vec%0d scoreboard empty", i);
         end else begin
            act = dut_out();
            check($sformatf("vec%0d ex_regs", i), 192'(act), 192'(sb_q.pop_front()));
         end
      end

      // Saturation: 65537 consecutive flush bubbles from a cleared counter.
      @(negedge clk);
      rst_n = 1'b0; flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; flush = 1'b1;
      #1;
      check("sat stall under flush", 192'(stall), 192'(0));
      repeat (65535) @(posedge clk);
      #1;
      check("sat cnt at 65535", 192'(cnt), 192'(16'hFFFF));
      repeat (2) @(posedge clk);
      #1;
      check("sat cnt at 65537", 192'(cnt), 192'(16'hFFFF));
      check("sat valid", 192'(valid_ex), 192'(0));
      @(negedge clk);
      flush = 1'b0; mr = 1'b0;
      @(posedge clk);
      #1;
      check("sat cnt after load", 192'(cnt), 192'(16'hFFFF));
      check("sat load valid", 192'(valid_ex), 192'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
